// File: rtl/struct_pkg.sv
// ---------------------------------------------------------------------------
// struct_pkg
// Shared types and constants for the RV32I pipeline front end.
//   if_t        : IF/ID register payload (isValid, instr, pc)
//   NOP_INSTR   : canonical RV32I NOP (addi x0, x0, 0)
//   INSTR_BYTES : byte stride between sequential instructions
//   IF_BUBBLE   : IF/ID value that carries no instruction
// ---------------------------------------------------------------------------
package struct_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic        isValid;
        logic [31:0] instr;
        logic [31:0] pc;
    } if_t;

    localparam if_t IF_BUBBLE = '{isValid: 1'b0, instr: NOP_INSTR, pc: 32'h0};

endpackage

// File: rtl/fetch_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding buffer for an instruction that returns from memory while
// decode is stalled.
//   clk, rst_n        : clock, asynchronous active-low reset
//   load              : capture new_instr/new_pc and mark the entry occupied
//   drain             : entry consumed downstream, mark it empty
//   flush             : discard the entry (highest priority)
//   new_instr, new_pc : data to capture
//   valid             : entry occupied
//   instr, pc         : stored entry
// ---------------------------------------------------------------------------
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] new_instr,
    input  logic [31:0] new_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= 32'h0;
            pc    <= 32'h0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= new_instr;
            pc    <= new_pc;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, issues reads to a synchronous
// instruction memory and registers the IF/ID payload for decode.
//   clk, rst_n             : clock, asynchronous active-low reset
//   stall                  : decode stall, IF/ID holds
//   redirect, redirect_pc  : taken branch/jump from EX (overrides stall)
//   imem_req, imem_addr    : combinational memory read strobe / address
//   imem_rdata             : read data, one cycle after an accepted request
//   if_out                 : IF/ID register
// ---------------------------------------------------------------------------
module fetch_stage
    import struct_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output if_t         if_out
);

    logic [31:0] pc_q;
    logic        pend_q;
    logic [31:0] pend_pc_q;

    logic        issue;
    logic        skid_load;
    logic        skid_drain;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    if_t         if_d;

    // issue is kept free of rst_n so the reset net only feeds async resets;
    // the external strobe is gated by reset separately.
    always_comb begin
        issue     = redirect | ~stall;
        imem_req  = rst_n & issue;
        imem_addr = (redirect ? redirect_pc : pc_q) & ~32'h3;

        skid_load  = pend_q & stall & ~redirect;
        skid_drain = skid_valid & ~stall & ~redirect;

        // A pending response and an occupied skid are mutually exclusive,
        // so the order of those two branches never matters.
        if_d = if_out;
        if (redirect) begin
            if_d = IF_BUBBLE;
        end else if (!stall) begin
            if (pend_q) begin
                if_d = '{isValid: 1'b1, instr: imem_rdata, pc: pend_pc_q};
            end else if (skid_valid) begin
                if_d = '{isValid: 1'b1, instr: skid_instr, pc: skid_pc};
            end else begin
                if_d = IF_BUBBLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'h0;
            if_out    <= IF_BUBBLE;
        end else begin
            if (issue) begin
                pc_q      <= imem_addr + INSTR_BYTES;
                pend_pc_q <= imem_addr;
            end
            pend_q <= issue;
            if_out <= if_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .drain     (skid_drain),
        .flush     (redirect),
        .new_instr (imem_rdata),
        .new_pc    (pend_pc_q),
        .valid     (skid_valid),
        .instr     (skid_instr),
        .pc        (skid_pc)
    );

    // Skid capture needs stall in the response cycle, and stall without
    // redirect blocks the next request, so both can never be live together.
    skid_pend_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n) !(skid_valid && pend_q)
    );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RV32I pipeline: owns the PC, issues requests to a synchronous instruction memory and produces the registered IF/ID payload (`if_t`) consumed by decode. It honours the decode-stage `stall` without losing in-flight instructions (1-entry skid buffer). It honours execute-stage `redirect` (taken branch/jump) by squashing wrong-path fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  pipeline clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  decode load-use stall; IF/ID must hold
- `redirect`  in  1  taken branch/jump from EX; overrides `stall`
- `redirect_pc`  in  32  target address, valid with `redirect`
- `imem_req`  out  1  instruction-memory read strobe (combinational)
- `imem_addr`  out  32  word-aligned read address (combinational)
- `imem_rdata`  in  32  read data, valid exactly one cycle after an accepted `imem_req`
- `if_out`  out  `if_t`  IF/ID register: `isValid`, `instr`, `pc`

## Operation
- State: `pc_q` (next sequential address), `pend_q` + `pend_pc_q` (request in flight), `skid_v`/`skid_instr`/`skid_pc`, `if_out` register.
- Request: `imem_req = redirect | ~stall`; `imem_addr = redirect ? redirect_pc : pc_q`. On an issued request, `pc_q <= imem_addr + 4` (32-bit wrap, no trap); `pend_q <= 1`, `pend_pc_q <= imem_addr`. No request means `pend_q <= 0`.
- Response (cycle with `pend_q=1`), evaluated with priority:
  - if `redirect`, squash it.
  - else if `stall`, write it to skid (`skid_v <= 1`).
  - else load it into `if_out` (`isValid=1`, `instr=imem_rdata`, `pc=pend_pc_q`).
- Skid drain: `skid_v & ~stall & ~redirect` loads `if_out` from skid and clears `skid_v`.
- Bubble: `~stall` with nothing to load (no response, no skid) loads `if_out` with `isValid=0`, `instr=NOP_INSTR`, `pc=0`.
- `stall` without redirect: `if_out`, `pc_q`, skid hold (except skid capture above).
- Redirect: `if_out` becomes a bubble, `skid_v <= 0`, in-flight response discarded, new request to `redirect_pc` issued the same cycle.
- Invariant (assert): `skid_v` and `pend_q` never both 1. A skid load requires `stall` in the response cycle, which blocks the request in that cycle.
- Misaligned `redirect_pc[1:0] != 0`: bits forced to 0 on `imem_addr`. Exceptions are out of scope.

## Timing
- Reset (async assert): `pc_q=RESET_PC`, `pend_q=0`, `skid_v=0`, `if_out.isValid=0`, `if_out.instr=NOP_INSTR`, `if_out.pc=0`. `imem_req` is forced 0 while `rst_n=0`.
- First request is in the first cycle after `rst_n` deasserts. First valid `if_out` is at the second rising edge after deassertion.
- Latency from request to `if_out`: 1 cycle with no stall. Throughput is 1 instr/cycle.
- Redirect penalty: exactly one bubble in `if_out`. Target instruction is valid on the edge after the cycle following `redirect`.
- Stall release: the skid instruction appears on the release edge. The sequential fetch resumes in the same cycle, so there is no bubble.
- Reset mid-stall or mid-redirect: all state returns to reset values immediately. The in-flight response is ignored because `pend_q=0`.

## Structure
- `if_t` lives in `struct_pkg`. Add `NOP_INSTR = 32'h0000_0013` and `INSTR_BYTES = 4` as package constants.
- Sub-module `fetch_skid_buf`: 1-entry buffer holding {instr, pc} with load/drain/flush and an occupancy flag. The top level contains the PC, the request logic and the IF/ID register.

## Test plan
- Reset release, `RESET_PC=0`, no stall → `imem_addr` 0,4,8,…. `if_out.pc` is 0,4,8 with `isValid=1` from the second edge onward.
- Stall for 3 cycles while 0x8 is in flight → `if_out` holds pc 0x4. 0x8 sits in skid and `imem_req=0` during the stall. On release `if_out.pc=0x8`, then 0xC on the next edge; no duplicate, no drop.
- `redirect=1`, `redirect_pc=0x100` while 0x10 is in flight → 0x10 is never valid. One bubble (`isValid=0`, `instr=0x13`), then `if_out.pc=0x100`, then 0x104.
- `redirect` and `stall` in the same cycle with skid full → skid cleared and `imem_addr=0x200`. `if_out` becomes a bubble, then pc 0x200 (or 0x200 held in skid if `stall` is still high).
- `pc_q=0xFFFF_FFFC` sequential fetch → next `imem_addr=0x0000_0000` (wrap).
- Assert `rst_n` low mid-stall with skid full → all outputs at reset values the same cycle. After release, fetch restarts at `RESET_PC`.
